// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU.
// Opcode map, FSM states and opcode legality check.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Kept as a function so the map can grow without touching the FSM.
    function automatic logic op_valid(input op_t o);
        unique case (o)
            OP_ADD, OP_SUB, OP_AND, OP_NOTB,
            OP_OR, OP_XOR, OP_SHL, OP_MUL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// prod is the accumulator value after the current step.
module seq_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               last
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign prod = acc + (mplier[0] ? mcand : '0);
    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (step) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus a multi-cycle multiply.
// Result and Z/V/N/err are registered and held until consumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             err
);

    localparam int MSB  = WIDTH - 1;
    localparam int SH_W = $clog2(WIDTH);

    state_t             state, state_nx;
    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   res;
    logic               res_v;
    logic [2*WIDTH-1:0] prod;
    logic               last;

    assign accept = in_valid && in_ready;
    assign is_mul = (op == OP_MUL);

    seq_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && is_mul),
        .step    (state == MUL),
        .a       (Ain),
        .b       (Bin),
        .prod    (prod),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = is_mul ? MUL : DONE;
            MUL:  if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        res   = '0;
        res_v = 1'b0;
        unique case (op)
            OP_ADD: begin
                res   = Ain + Bin;
                res_v = (Ain[MSB] == Bin[MSB]) && (res[MSB] != Ain[MSB]);
            end
            OP_SUB: begin
                res   = Ain - Bin;
                res_v = (Ain[MSB] != Bin[MSB]) && (res[MSB] != Ain[MSB]);
            end
            OP_AND:  res = Ain & Bin;
            OP_NOTB: res = ~Bin;
            OP_OR:   res = Ain | Bin;
            OP_XOR:  res = Ain ^ Bin;
            OP_SHL:  res = Ain << Bin[SH_W-1:0];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
            Z   <= 1'b0;
            V   <= 1'b0;
            N   <= 1'b0;
            err <= 1'b0;
        end else if (accept && !is_mul) begin
            if (!op_valid(op)) begin
                out <= '0;
                Z   <= 1'b1;
                V   <= 1'b0;
                N   <= 1'b0;
                err <= 1'b1;
            end else begin
                out <= res;
                Z   <= (res == '0);
                V   <= res_v;
                N   <= res[MSB];
                err <= 1'b0;
            end
        end else if (state == MUL && last) begin
            out <= prod[WIDTH-1:0];
            Z   <= (prod[WIDTH-1:0] == '0);
            V   <= |prod[2*WIDTH-1:WIDTH];
            N   <= prod[MSB];
            err <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the lab combinational ALU.
- Adds OR, XOR, logical shifts and an iterative unsigned multiply.
- Result and Z/V/N status are registered and held until consumed.
- Sits between the register-file operand latches and the writeback/status register of the datapath. It replaces the combinational ALU wherever a multi-cycle MUL is required.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4).
CNT_W, $clog2(WIDTH+1), multiply step counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept a new operation
op  input  3  operation code (alu_seq_pkg::op_t)
Ain  input  WIDTH  operand A
Bin  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes result
out  output  WIDTH  result
Z  output  1  out == 0
V  output  1  signed overflow (ADD/SUB) or product overflow (MUL)
N  output  1  out[WIDTH-1]
err  output  1  illegal op code accepted

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state IDLE; out = 0; Z = N = V = err = 0; out_valid = 0. in_ready is 1 once reset_n is high.
- Reset asserted mid-operation aborts it immediately. No result is produced. The block returns to IDLE.
- States:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: in_valid & in_ready at a rising edge. op, Ain and Bin are sampled on that edge only. Later input changes are ignored.
- Opcodes and results:
  - ADD 000: A+B.
  - SUB 001: A-B.
  - AND 010: A&B.
  - NOTB 011: ~B.
  - OR 100: A|B.
  - XOR 101: A^B.
  - SHL 110: A << B[$clog2(WIDTH)-1:0], zero fill.
  - MUL 111: low WIDTH bits of unsigned A*B.
- Illegal code: none at WIDTH=16 with the 3-bit map. err is driven from alu_seq_pkg::op_valid(); it is reserved for future map growth. When err is set, out = 0 and Z = 1.
- Non-MUL ops: result and flags are registered on the accept edge. Next state is DONE, so out_valid is high in the cycle immediately after the accept cycle (latency 1).
- MUL: the accept edge loads the multiplicand, multiplier and a zeroed 2*WIDTH accumulator, and sets cnt = WIDTH.
  - Each MUL-state edge does one shift-add step and decrements cnt.
  - The step with cnt == 1 writes out/flags and moves to DONE.
  - Latency is WIDTH+1 cycles: 17 at the default.
- Flags:
  - Z = (out == 0).
  - N = out[WIDTH-1] for every op.
  - V for ADD: two's-complement overflow, (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
  - V for SUB: overflow of A + ~B + 1.
  - V for MUL: OR of the product's upper WIDTH bits.
  - V = 0 for logic ops and shifts.
- DONE: out, Z, V, N and err are held stable while out_ready = 0. When out_ready = 1 the result is consumed and the next state is IDLE. There is no accept in the same cycle, so peak throughput is one op per 2 cycles.
- in_valid while not in_ready: ignored. It is not queued.
- Output registers keep their last value in IDLE. Only out_valid qualifies them.

Decomposition:
- Package alu_seq_pkg:
  - op_t enum (3-bit codes above).
  - state_t enum {IDLE, MUL, DONE}.
  - function op_valid(op_t).
- Sub-module seq_mul #(WIDTH): shift-add datapath with start, step and cnt, exposing prod[2*WIDTH-1:0] and last.
- alu_seq holds the handshake FSM, the single-cycle ops and the flag logic.

Test Plan:
- ADD Ain=16'h7FFF, Bin=16'h0001 -> out_valid in the cycle after accept. out=16'h8000, N=1, V=1, Z=0.
- SUB Ain=16'h0005, Bin=16'h0005 -> out=16'h0000, Z=1, N=0, V=0. SUB 16'h8000-16'h0001 -> out=16'h7FFF, V=1.
- MUL Ain=16'h0100, Bin=16'h0100 -> in_ready low for 17 cycles; out_valid in the 17th cycle after accept. out=16'h0000, Z=1, V=1. MUL 16'h00FF*16'h0003 -> out=16'h02FD, V=0.
- Backpressure: OR 16'h0F0F|16'hF000, hold out_ready=0 for 5 cycles -> out=16'hFF0F, N=1 stable with out_valid=1 and in_ready=0 throughout. out_ready=1 -> IDLE next cycle.
- SHL Ain=16'h0001, Bin=16'h001F (uses low 4 bits = 15) -> out=16'h8000, N=1, V=0. XOR equal operands -> Z=1.
- Reset: drop reset_n in MUL cycle 8 -> out_valid=0, out=0 and all flags 0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.
